pulse_train_gen: RTL and testbench
==================================

Name: pulse_train_gen

Overview:
Multi-channel programmable pulse generator, replacing the fixed 5-unit, free-running pulse block. Each channel emits a train of synchronous pulses with programmable high width, period and pulse count. It is driven by the system clock generator and feeds timing/strobe consumers in the lab designs. Channels are independent and are configured over a shared write port.

Parameters:
CHANNELS, 4, number of independent pulse channels (1..16)
CH_W, 2, width of the channel-select field; 2**CH_W >= CHANNELS
CNT_W, 8, width of the width/period/count fields and internal counters
WIDTH_DEF, 5, reset value of each channel's width register (cycles)
PERIOD_DEF, 24, reset value of each channel's period register (cycles)
COUNT_DEF, 0, reset value of each channel's count register (0 = continuous)

Ports:
clock  in  1  system clock; all state changes on its rising edge
reset  in  1  synchronous, active-high reset
cfg_we  in  1  config write strobe
cfg_ch  in  CH_W  channel addressed by the write
cfg_width  in  CNT_W  high time in cycles
cfg_period  in  CNT_W  pulse period in cycles
cfg_count  in  CNT_W  pulses per train (0 = continuous)
start  in  CHANNELS  per-channel start request (level, sampled each edge)
stop  in  CHANNELS  per-channel abort request
signal  out  CHANNELS  pulse outputs, registered
busy  out  CHANNELS  1 while a channel is in HIGH or LOW
done  out  CHANNELS  1-cycle strobe when a finite train completes

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Reset: signal=0, busy=0, done=0; all channels IDLE; config registers = WIDTH_DEF/PERIOD_DEF/COUNT_DEF; counters cleared. Reset mid-train aborts it at once, with no done.
- Config: when cfg_we=1 and cfg_ch<CHANNELS, write width/period/count of channel cfg_ch on the edge. cfg_ch>=CHANNELS: write dropped. Writes are always accepted. A running channel uses an active copy latched at start, so new values take effect only on the next start.
- Per-channel FSM, states IDLE, HIGH, LOW:
  - IDLE -> HIGH on an edge sampling start[i]=1, stop[i]=0, width!=0. Latch the active copy and set the pulse counter to count. signal[i]=1 and busy[i]=1 from that edge (latency 1 cycle from start assertion).
  - start with width=0: ignored, stays IDLE.
  - HIGH lasts exactly W cycles, then moves to LOW with signal=0.
  - LOW lasts L = P-W cycles. If P<=W, L=1 (minimum 1-cycle gap).
  - End of LOW, continuous mode (count=0): back to HIGH.
  - End of LOW, finite mode: decrement the counter. If nonzero, back to HIGH. If zero, go to IDLE with busy=0 and done=1 for one cycle.
  - Successive pulses in a train: rising edges exactly max(P, W+1) cycles apart.
  - stop[i]=1 in HIGH or LOW: go to IDLE on that edge; signal=0, busy=0, no done.
  - start and stop both 1 in IDLE: stop wins, no start.
  - start while busy: ignored (no retrigger).
  - start held high after done: a new train starts on the edge after done asserts (done and the new HIGH cannot coincide).
- Counters are CNT_W bits unsigned; width/period of 2**CNT_W-1 must work without wrap.

Optional Feature:
PULSE_NEGEDGE_EN: when defined, each signal bit passes through an extra flop clocked on the falling edge of clock. Pulses then align to the falling edge, half a cycle later than the posedge timing above. Widths and periods are unchanged. This flop clears when reset is sampled high on a falling edge. busy and done stay posedge-timed.
Undefined: signal comes straight from the posedge state register.

Test Plan:
- Reset, then start[0]=1 for 1 cycle with defaults (W=5, P=24, count=0) -> signal[0] high 5 cycles, low 19, repeating every 24 cycles; busy[0]=1 throughout; done never.
- Ch1 cfg W=3, P=8, count=2, start -> exactly 2 pulses of 3 cycles, rising edges 8 apart; done[1]=1 for one cycle after the 2nd LOW; busy[1]=0 after.
- Ch2 W=6, P=4, count=1 -> 6-cycle pulse, 1-cycle low, then done; ch2 W=0, start -> no activity.
- Ch3 running continuous, stop[3] mid-HIGH -> signal[3]=0 and busy[3]=0 next edge, no done; start+stop together in IDLE -> stays IDLE.
- Ch0 running, cfg_we to ch0 with W=2 -> current train unchanged; after stop and restart, pulses are 2 cycles. Write with cfg_ch=7 when CHANNELS=4 -> no register changes.
- All 4 channels started on the same edge with different configs, then reset asserted at cycle 30 -> all outputs 0 next edge; config returns to defaults. Repeat with PULSE_NEGEDGE_EN: every signal edge shifted half a clock.

Source files
------------

// File: rtl/pulse_train_gen.sv
// Multi-channel programmable pulse-train generator: per-channel width/period/count
// with a shared config write port. Define PULSE_NEGEDGE_EN to re-time signal on the falling edge.
module pulse_train_gen #(
  parameter int CHANNELS   = 4,
  parameter int CH_W       = 2,
  parameter int CNT_W      = 8,
  parameter int WIDTH_DEF  = 5,
  parameter int PERIOD_DEF = 24,
  parameter int COUNT_DEF  = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_width,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [CNT_W-1:0]    cfg_count,
  input  logic [CHANNELS-1:0] start,
  input  logic [CHANNELS-1:0] stop,
  output logic [CHANNELS-1:0] signal,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } state_t;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [CNT_W-1:0] width_reg, period_reg, count_reg;
      logic [CNT_W-1:0] act_w_reg, act_w_next;
      logic [CNT_W-1:0] act_l_reg, act_l_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic [CNT_W-1:0] phase_reg, phase_next;
      logic [CNT_W-1:0] low_len;
      state_t           state_reg, state_next;
      logic             sig_reg;
      logic             done_reg, done_next;
      logic             cfg_hit;

      // An out-of-range cfg_ch matches no channel, so the write is simply dropped.
      assign cfg_hit = cfg_we && (cfg_ch == CH_W'(gi));
      assign low_len = (period_reg > width_reg) ? (period_reg - width_reg) : CNT_W'(1);

      always_comb begin
        state_next = state_reg;
        act_w_next = act_w_reg;
        act_l_next = act_l_reg;
        cnt_next   = cnt_reg;
        phase_next = phase_reg;
        done_next  = 1'b0;
        case (state_reg)
          ST_IDLE: begin
            if (start[gi] && !stop[gi] && (width_reg != '0)) begin
              state_next = ST_HIGH;
              act_w_next = width_reg;
              act_l_next = low_len;
              cnt_next   = count_reg;
              phase_next = width_reg - CNT_W'(1);
            end
          end
          ST_HIGH: begin
            if (stop[gi]) begin
              state_next = ST_IDLE;
            end else if (phase_reg == '0) begin
              state_next = ST_LOW;
              phase_next = act_l_reg - CNT_W'(1);
            end else begin
              phase_next = phase_reg - CNT_W'(1);
            end
          end
          ST_LOW: begin
            if (stop[gi]) begin
              state_next = ST_IDLE;
            end else if (phase_reg == '0) begin
              // Zero pulse count means continuous; otherwise the last LOW ends the train.
              if (cnt_reg == CNT_W'(1)) begin
                state_next = ST_IDLE;
                cnt_next   = '0;
                done_next  = 1'b1;
              end else begin
                state_next = ST_HIGH;
                phase_next = act_w_reg - CNT_W'(1);
                if (cnt_reg != '0) cnt_next = cnt_reg - CNT_W'(1);
              end
            end else begin
              phase_next = phase_reg - CNT_W'(1);
            end
          end
          default: state_next = ST_IDLE;
        endcase
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          state_reg  <= ST_IDLE;
          act_w_reg  <= '0;
          act_l_reg  <= '0;
          cnt_reg    <= '0;
          phase_reg  <= '0;
          sig_reg    <= 1'b0;
          done_reg   <= 1'b0;
          width_reg  <= CNT_W'(WIDTH_DEF);
          period_reg <= CNT_W'(PERIOD_DEF);
          count_reg  <= CNT_W'(COUNT_DEF);
        end else begin
          state_reg <= state_next;
          act_w_reg <= act_w_next;
          act_l_reg <= act_l_next;
          cnt_reg   <= cnt_next;
          phase_reg <= phase_next;
          sig_reg   <= (state_next == ST_HIGH);
          done_reg  <= done_next;
          if (cfg_hit) begin
            width_reg  <= cfg_width;
            period_reg <= cfg_period;
            count_reg  <= cfg_count;
          end
        end
      end

`ifdef PULSE_NEGEDGE_EN
      logic sig_neg_reg;
      always_ff @(negedge clock) begin
        if (reset) sig_neg_reg <= 1'b0;
        else       sig_neg_reg <= sig_reg;
      end
      assign signal[gi] = sig_neg_reg;
`else
      assign signal[gi] = sig_reg;
`endif
      assign busy[gi] = (state_reg != ST_IDLE);
      assign done[gi] = done_reg;
    end
  endgenerate

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen: traces each channel cycle by cycle and
// compares against hand-computed bit patterns (bit k = sample k cycles after start).
module tb_pulse_train_gen;
  localparam int CHANNELS = 4;
  localparam int CH_W     = 3;
  localparam int CNT_W    = 8;

  logic                clock = 1'b0;
  logic                reset;
  logic                cfg_we;
  logic [CH_W-1:0]     cfg_ch;
  logic [CNT_W-1:0]    cfg_width, cfg_period, cfg_count;
  logic [CHANNELS-1:0] start, stop;
  logic [CHANNELS-1:0] signal, busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sig_tr  [CHANNELS];
  logic [63:0] busy_tr [CHANNELS];
  logic [63:0] done_tr [CHANNELS];

  pulse_train_gen #(
    .CHANNELS(CHANNELS), .CH_W(CH_W), .CNT_W(CNT_W),
    .WIDTH_DEF(5), .PERIOD_DEF(24), .COUNT_DEF(0)
  ) dut (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_width(cfg_width), .cfg_period(cfg_period), .cfg_count(cfg_count),
    .start(start), .stop(stop), .signal(signal), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance one cycle and settle away from the active edge.
  task automatic tick();
    @(posedge clock);
`ifdef PULSE_NEGEDGE_EN
    @(negedge clock);
`endif
    #2;
  endtask

  task automatic trace(input int n);
    for (int c = 0; c < CHANNELS; c++) begin
      sig_tr[c] = '0; busy_tr[c] = '0; done_tr[c] = '0;
    end
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < CHANNELS; c++) begin
        sig_tr[c][k]  = signal[c];
        busy_tr[c][k] = busy[c];
        done_tr[c][k] = done[c];
      end
      tick();
    end
  endtask

  task automatic cfg(input int ch, input int w, input int p, input int cnt);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch);
    cfg_width = CNT_W'(w); cfg_period = CNT_W'(p); cfg_count = CNT_W'(cnt);
    tick();
    cfg_we = 1'b0;
  endtask

  // Continuous train: high for w cycles out of every p, starting at phase off.
  function automatic logic [63:0] cont_pat(input int w, input int p, input int off, input int n);
    logic [63:0] r = '0;
    for (int k = 0; k < n; k++) r[k] = ((k + off) % p) < w;
    return r;
  endfunction

  function automatic logic [63:0] ones(input int n);
    logic [63:0] r = '0;
    for (int k = 0; k < n; k++) r[k] = 1'b1;
    return r;
  endfunction

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0;
    cfg_width = '0; cfg_period = '0; cfg_count = '0;
    start = '0; stop = '0;
    tick(); tick();
    chk("rst_signal", 64'(signal), 64'h0);
    chk("rst_busy",   64'(busy),   64'h0);
    chk("rst_done",   64'(done),   64'h0);
    reset = 1'b0;
    tick();

    // Ch0 defaults, continuous
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    trace(48);
    chk("ch0_def_sig",  sig_tr[0],  cont_pat(5, 24, 0, 48));
    chk("ch0_def_busy", busy_tr[0], ones(48));
    chk("ch0_def_done", done_tr[0], 64'h0);

    // Reconfigure ch0 while running: active train unchanged
    cfg(0, 2, 24, 0);
    trace(30);
    chk("ch0_live_cfg_sig", sig_tr[0], cont_pat(5, 24, 49, 30));
    stop[0] = 1'b1; tick(); stop[0] = 1'b0;
    chk("ch0_stop_sig",  64'(signal[0]), 64'h0);
    chk("ch0_stop_busy", 64'(busy[0]),   64'h0);
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    trace(30);
    chk("ch0_new_w2_sig", sig_tr[0], cont_pat(2, 24, 0, 30));
    stop[0] = 1'b1; tick(); stop[0] = 1'b0;

    // Ch1 finite train of 2
    cfg(1, 3, 8, 2);
    start[1] = 1'b1; tick(); start[1] = 1'b0;
    trace(20);
    chk("ch1_fin_sig",  sig_tr[1],  64'h0707);
    chk("ch1_fin_busy", busy_tr[1], 64'hFFFF);
    chk("ch1_fin_done", done_tr[1], 64'h10000);

    // Start held: no retrigger while busy, new train the edge after done
    start[1] = 1'b1; tick();
    trace(20);
    chk("ch1_hold_sig",  sig_tr[1],  64'hE0707);
    chk("ch1_hold_busy", busy_tr[1], 64'hEFFFF);
    chk("ch1_hold_done", done_tr[1], 64'h10000);
    start[1] = 1'b0; stop[1] = 1'b1; tick(); stop[1] = 1'b0;

    // Ch2 period shorter than width: 1-cycle gap
    cfg(2, 6, 4, 1);
    start[2] = 1'b1; tick(); start[2] = 1'b0;
    trace(10);
    chk("ch2_short_p_sig",  sig_tr[2],  64'h3F);
    chk("ch2_short_p_busy", busy_tr[2], 64'h7F);
    chk("ch2_short_p_done", done_tr[2], 64'h80);
    cfg(2, 0, 4, 0);
    start[2] = 1'b1; tick(); start[2] = 1'b0;
    trace(6);
    chk("ch2_w0_sig",  sig_tr[2],  64'h0);
    chk("ch2_w0_busy", busy_tr[2], 64'h0);

    // Ch3 stop mid-HIGH, then start+stop together
    start[3] = 1'b1; tick(); start[3] = 1'b0;
    tick(); tick();
    chk("ch3_pre_stop_sig", 64'(signal[3]), 64'h1);
    stop[3] = 1'b1; tick(); stop[3] = 1'b0;
    chk("ch3_stop_sig",  64'(signal[3]), 64'h0);
    chk("ch3_stop_busy", 64'(busy[3]),   64'h0);
    trace(4);
    chk("ch3_stop_no_done", done_tr[3], 64'h0);
    start[3] = 1'b1; stop[3] = 1'b1; tick(); start[3] = 1'b0; stop[3] = 1'b0;
    trace(3);
    chk("ch3_start_stop_busy", busy_tr[3], 64'h0);

    // Out-of-range channel write must not touch any channel
    cfg(7, 1, 2, 1);
    start = 4'b1010; tick(); start = '0;
    trace(30);
    chk("cfg7_ch1_sig", sig_tr[1], 64'h0707);
    chk("cfg7_ch3_sig", sig_tr[3], cont_pat(5, 24, 0, 30));
    stop = 4'b1010; tick(); stop = '0;

    // All channels together, then reset at cycle 30
    cfg(2, 4, 10, 0);
    start = 4'b1111; tick(); start = '0;
    trace(30);
    chk("all_ch0_sig",  sig_tr[0],  cont_pat(2, 24, 0, 30));
    chk("all_ch1_sig",  sig_tr[1],  64'h0707);
    chk("all_ch1_done", done_tr[1], 64'h10000);
    chk("all_ch2_sig",  sig_tr[2],  cont_pat(4, 10, 0, 30));
    chk("all_ch3_sig",  sig_tr[3],  cont_pat(5, 24, 0, 30));
    reset = 1'b1; tick();
    chk("midrst_signal", 64'(signal), 64'h0);
    chk("midrst_busy",   64'(busy),   64'h0);
    chk("midrst_done",   64'(done),   64'h0);
    reset = 1'b0; tick();

    // Config back at defaults after reset
    start = 4'b0110; tick(); start = '0;
    trace(30);
    chk("post_rst_ch1_sig",  sig_tr[1],  cont_pat(5, 24, 0, 30));
    chk("post_rst_ch2_sig",  sig_tr[2],  cont_pat(5, 24, 0, 30));
    chk("post_rst_ch1_busy", busy_tr[1], ones(30));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
